spike_avl_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares the single Avalon slave port of the spike detection block between the host register bridge (master 0) and the autonomous acquisition controller (master 1). It grants the slave to one master at a time with round-robin priority, holds the grant until the transfer completes, routes read data back to the owner, and recovers from a missing read response with a timeout. It sits directly in front of the slave port; the slave's IRQ passes through unchanged.

---
 rtl/spike_avl_arbiter.sv | 144 ++++++++++++++
 tb/tb_spike_avl_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_avl_arbiter.sv
// Two-master Avalon-MM arbiter for the spike detection slave port.
// Round-robin grant, grant held until the transfer completes, read timeout recovery.
module spike_avl_arbiter #(
  parameter int unsigned RD_TIMEOUT   = 16,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_n_i,
  input  logic [13:0] m0_address_i,
  input  logic [3:0]  m0_byteenable_i,
  input  logic        m0_write_i,
  input  logic        m0_read_i,
  input  logic [15:0] m0_writedata_i,
  output logic [15:0] m0_readdata_o,
  output logic        m0_readdatavalid_o,
  output logic        m0_waitrequest_o,
  input  logic [13:0] m1_address_i,
  input  logic [3:0]  m1_byteenable_i,
  input  logic        m1_write_i,
  input  logic        m1_read_i,
  input  logic [15:0] m1_writedata_i,
  output logic [15:0] m1_readdata_o,
  output logic        m1_readdatavalid_o,
  output logic        m1_waitrequest_o,
  output logic [13:0] s_address_o,
  output logic [3:0]  s_byteenable_o,
  output logic [15:0] s_writedata_o,
  output logic        s_write_o,
  output logic        s_read_o,
  input  logic [15:0] s_readdata_i,
  input  logic        s_readdatavalid_i,
  input  logic        s_waitrequest_i,
  input  logic        s_irq_i,
  output logic        irq_o,
  output logic        owner_o,
  output logic        err_timeout_o,
  output logic        err_stray_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RD_WAIT} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req0, req1;
  logic        own_wr, own_rd;
  logic        rdv;
  logic [15:0] rdata;
  logic        timeout;
  logic        xfer0, xfer1;

  assign req0 = m0_write_i | m0_read_i;
  assign req1 = m1_write_i | m1_read_i;

  // A simultaneous write and read is resolved in favour of the write.
  assign own_wr = owner_q ? m1_write_i : m0_write_i;
  assign own_rd = (owner_q ? m1_read_i : m0_read_i) & ~own_wr;

  always_ff @(posedge avl_clk_i or negedge avl_reset_n_i) begin
    if (!avl_reset_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    s_address_o    = '0;
    s_byteenable_o = '0;
    s_writedata_o  = '0;
    s_write_o      = 1'b0;
    s_read_o       = 1'b0;
    rdv            = 1'b0;
    rdata          = '0;
    timeout        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          owner_d = ~owner_q;
          state_d = ST_XFER;
        end else if (req0) begin
          owner_d = 1'b0;
          state_d = ST_XFER;
        end else if (req1) begin
          owner_d = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        s_address_o    = owner_q ? m1_address_i    : m0_address_i;
        s_byteenable_o = owner_q ? m1_byteenable_i : m0_byteenable_i;
        s_writedata_o  = owner_q ? m1_writedata_i  : m0_writedata_i;
        s_write_o      = own_wr;
        s_read_o       = own_rd;
        // An owner that withdrew its strobe while stalled releases the slave.
        if (!own_wr && !own_rd) begin
          state_d = ST_IDLE;
        end else if (!s_waitrequest_i) begin
          state_d = own_wr ? ST_IDLE : ST_RD_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RD_WAIT: begin
        if (s_readdatavalid_i) begin
          rdv     = 1'b1;
          rdata   = s_readdata_i;
          state_d = ST_IDLE;
        end else if (cnt_q == 8'(RD_TIMEOUT - 1)) begin
          rdv     = 1'b1;
          rdata   = TIMEOUT_DATA;
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer0 = (state_q == ST_XFER) & ~owner_q;
  assign xfer1 = (state_q == ST_XFER) &  owner_q;

  assign m0_waitrequest_o   = xfer0 ? s_waitrequest_i : req0;
  assign m1_waitrequest_o   = xfer1 ? s_waitrequest_i : req1;
  assign m0_readdatavalid_o = rdv & ~owner_q;
  assign m1_readdatavalid_o = rdv &  owner_q;
  assign m0_readdata_o      = m0_readdatavalid_o ? rdata : '0;
  assign m1_readdata_o      = m1_readdatavalid_o ? rdata : '0;

  assign owner_o       = owner_q;
  assign irq_o         = s_irq_i;
  assign err_timeout_o = timeout;
  // Gated by reset so a response arriving while reset is held stays silent.
  assign err_stray_o   = s_readdatavalid_i & (state_q != ST_RD_WAIT) & avl_reset_n_i;

endmodule

// File: tb/tb_spike_avl_arbiter.sv
// Scenario bench for spike_avl_arbiter; read responses are checked against a queue of expected results.
module tb_spike_avl_arbiter;

  logic        clk;
  logic        rst_n;
  logic [13:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic        m0_wr, m0_rd, m1_wr, m1_rd;
  logic [15:0] m0_wd, m1_wd;
  logic [15:0] m0_readdata_o, m1_readdata_o;
  logic        m0_readdatavalid_o, m1_readdatavalid_o;
  logic        m0_waitrequest_o, m1_waitrequest_o;
  logic [13:0] s_address_o;
  logic [3:0]  s_byteenable_o;
  logic [15:0] s_writedata_o;
  logic        s_write_o, s_read_o;
  logic [15:0] s_rdata;
  logic        s_rdv, s_wait, s_irq;
  logic        irq_o, owner_o, err_timeout_o, err_stray_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        m;
    logic [15:0] d;
  } exp_t;
  exp_t exp_q[$];

  spike_avl_arbiter #(.RD_TIMEOUT(16), .TIMEOUT_DATA(16'hDEAD)) dut (
    .avl_clk_i          (clk),
    .avl_reset_n_i      (rst_n),
    .m0_address_i       (m0_addr),
    .m0_byteenable_i    (m0_be),
    .m0_write_i         (m0_wr),
    .m0_read_i          (m0_rd),
    .m0_writedata_i     (m0_wd),
    .m0_readdata_o      (m0_readdata_o),
    .m0_readdatavalid_o (m0_readdatavalid_o),
    .m0_waitrequest_o   (m0_waitrequest_o),
    .m1_address_i       (m1_addr),
    .m1_byteenable_i    (m1_be),
    .m1_write_i         (m1_wr),
    .m1_read_i          (m1_rd),
    .m1_writedata_i     (m1_wd),
    .m1_readdata_o      (m1_readdata_o),
    .m1_readdatavalid_o (m1_readdatavalid_o),
    .m1_waitrequest_o   (m1_waitrequest_o),
    .s_address_o        (s_address_o),
    .s_byteenable_o     (s_byteenable_o),
    .s_writedata_o      (s_writedata_o),
    .s_write_o          (s_write_o),
    .s_read_o           (s_read_o),
    .s_readdata_i       (s_rdata),
    .s_readdatavalid_i  (s_rdv),
    .s_waitrequest_i    (s_wait),
    .s_irq_i            (s_irq),
    .irq_o              (irq_o),
    .owner_o            (owner_o),
    .err_timeout_o      (err_timeout_o),
    .err_stray_o        (err_stray_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every readdatavalid pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (m0_readdatavalid_o === 1'b1 || m1_readdatavalid_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected m0_rdv=%b m1_rdv=%b m0_data=%h m1_data=%h expected=none",
                 m0_readdatavalid_o, m1_readdatavalid_o, m0_readdata_o, m1_readdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({m0_readdatavalid_o, m1_readdatavalid_o} !== (e.m ? 2'b01 : 2'b10) ||
            (e.m ? m1_readdata_o : m0_readdata_o) !== e.d) begin
          n_err++;
          $display("FAIL sb_response m0_rdv=%b m1_rdv=%b m0_data=%h m1_data=%h expected master=%0d data=%h",
                   m0_readdatavalid_o, m1_readdatavalid_o, m0_readdata_o, m1_readdata_o, e.m, e.d);
        end
      end
    end
    n_cmp++;
    if ((m0_readdatavalid_o !== 1'b1 && m0_readdata_o !== 16'h0) ||
        (m1_readdatavalid_o !== 1'b1 && m1_readdata_o !== 16'h0)) begin
      n_err++;
      $display("FAIL readdata_idle_zero m0_data=%h m1_data=%h expected 0000 when not valid",
               m0_readdata_o, m1_readdata_o);
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    {m0_addr, m1_addr, m0_be, m1_be, m0_wr, m0_rd, m1_wr, m1_rd} = '0;
    {m0_wd, m1_wd, s_rdata, s_rdv, s_wait, s_irq} = '0;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (owner_o !== 1'b1) begin n_err++; $display("FAIL rst_owner got=%b exp=1", owner_o); end
    n_cmp++; if ({s_write_o, s_read_o} !== 2'b00) begin n_err++; $display("FAIL rst_strobes got=%b exp=00", {s_write_o, s_read_o}); end
    n_cmp++; if ({s_address_o, s_byteenable_o, s_writedata_o} !== '0) begin n_err++; $display("FAIL rst_cmd got=%h exp=0", {s_address_o, s_byteenable_o, s_writedata_o}); end
    n_cmp++; if ({m0_waitrequest_o, m1_waitrequest_o, err_timeout_o, err_stray_o} !== 4'b0000) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {m0_waitrequest_o, m1_waitrequest_o, err_timeout_o, err_stray_o}); end
    m0_rd = 1'b1; s_rdv = 1'b1; s_irq = 1'b1;
    #1;
    n_cmp++; if (m0_waitrequest_o !== 1'b1) begin n_err++; $display("FAIL rst_wait_req got=%b exp=1", m0_waitrequest_o); end
    n_cmp++; if (err_stray_o !== 1'b0) begin n_err++; $display("FAIL rst_stray got=%b exp=0", err_stray_o); end
    n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_high got=%b exp=1", irq_o); end
    m0_rd = 1'b0; s_rdv = 1'b0; s_irq = 1'b0;
    #1;
    n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_low got=%b exp=0", irq_o); end
    samp();
    rst_n = 1'b1;
  endtask

  task automatic test_rr_read();
    drv(); m0_rd = 1'b1; m0_addr = 14'd2; m1_rd = 1'b1; m1_addr = 14'd3;
    exp_q.push_back('{m: 1'b0, d: 16'h1234});
    exp_q.push_back('{m: 1'b1, d: 16'h5678});
    samp();
    n_cmp++; if ({m0_waitrequest_o, m1_waitrequest_o, s_read_o} !== 3'b110) begin n_err++; $display("FAIL rr_req got=%b exp=110", {m0_waitrequest_o, m1_waitrequest_o, s_read_o}); end
    drv(); samp();
    n_cmp++; if ({s_read_o, m0_waitrequest_o, m1_waitrequest_o, owner_o} !== 4'b1010 || s_address_o !== 14'd2) begin n_err++; $display("FAIL rr_grant0 got=%b addr=%0d exp=1010 addr=2", {s_read_o, m0_waitrequest_o, m1_waitrequest_o, owner_o}, s_address_o); end
    drv(); m0_rd = 1'b0; samp();
    n_cmp++; if ({s_read_o, m1_waitrequest_o} !== 2'b01) begin n_err++; $display("FAIL rr_wait0 got=%b exp=01", {s_read_o, m1_waitrequest_o}); end
    drv(); s_rdv = 1'b1; s_rdata = 16'h1234; samp();
    n_cmp++; if (m1_readdatavalid_o !== 1'b0) begin n_err++; $display("FAIL rr_m1_quiet got=%b exp=0", m1_readdatavalid_o); end
    drv(); s_rdv = 1'b0; samp();
    n_cmp++; if ({m1_waitrequest_o, s_read_o} !== 2'b10) begin n_err++; $display("FAIL rr_idle got=%b exp=10", {m1_waitrequest_o, s_read_o}); end
    drv(); samp();
    n_cmp++; if ({s_read_o, m1_waitrequest_o, owner_o} !== 3'b101 || s_address_o !== 14'd3) begin n_err++; $display("FAIL rr_grant1 got=%b addr=%0d exp=101 addr=3", {s_read_o, m1_waitrequest_o, owner_o}, s_address_o); end
    drv(); m1_rd = 1'b0; samp();
    drv(); s_rdv = 1'b1; s_rdata = 16'h5678; samp();
    n_cmp++; if (m0_readdatavalid_o !== 1'b0) begin n_err++; $display("FAIL rr_m0_quiet got=%b exp=0", m0_readdatavalid_o); end
    drv(); s_rdv = 1'b0; samp();
  endtask

  task automatic test_write();
    drv(); m0_wr = 1'b1; m0_addr = 14'd1; m0_wd = 16'd1; m0_be = 4'hF; samp();
    n_cmp++; if ({m0_waitrequest_o, s_write_o} !== 2'b10) begin n_err++; $display("FAIL wr_t got=%b exp=10", {m0_waitrequest_o, s_write_o}); end
    drv(); samp();
    n_cmp++; if ({s_write_o, m0_waitrequest_o, owner_o} !== 3'b100 || s_address_o !== 14'd1 ||
                 s_writedata_o !== 16'd1 || s_byteenable_o !== 4'hF) begin
      n_err++; $display("FAIL wr_t1 got=%b addr=%0d data=%h be=%h exp=100 addr=1 data=0001 be=f",
                        {s_write_o, m0_waitrequest_o, owner_o}, s_address_o, s_writedata_o, s_byteenable_o);
    end
    drv(); m0_wr = 1'b0; samp();
    n_cmp++; if (s_write_o !== 1'b0) begin n_err++; $display("FAIL wr_t2 got=%b exp=0", s_write_o); end
  endtask

  task automatic test_stall();
    int unsigned wcnt = 0;
    drv(); m1_wr = 1'b1; m1_addr = 14'd5; m1_wd = 16'hBEEF; m1_be = 4'h3; s_wait = 1'b1; samp();
    wcnt += 32'(m1_waitrequest_o);
    for (int unsigned i = 1; i <= 5; i++) begin
      drv();
      if (i == 1) begin m0_wr = 1'b1; m0_addr = 14'd7; m0_wd = 16'h0077; end
      samp();
      wcnt += 32'(m1_waitrequest_o);
      n_cmp++; if ({s_write_o, m0_waitrequest_o} !== 2'b11 || s_address_o !== 14'd5 ||
                   s_writedata_o !== 16'hBEEF || s_byteenable_o !== 4'h3) begin
        n_err++; $display("FAIL stall_cmd cyc=%0d got=%b addr=%0d data=%h be=%h exp=11 addr=5 data=beef be=3",
                          i, {s_write_o, m0_waitrequest_o}, s_address_o, s_writedata_o, s_byteenable_o);
      end
    end
    drv(); s_wait = 1'b0; samp();
    wcnt += 32'(m1_waitrequest_o);
    n_cmp++; if ({s_write_o, m1_waitrequest_o, m0_waitrequest_o} !== 3'b101) begin n_err++; $display("FAIL stall_accept got=%b exp=101", {s_write_o, m1_waitrequest_o, m0_waitrequest_o}); end
    n_cmp++; if (wcnt !== 6) begin n_err++; $display("FAIL stall_wait_cycles got=%0d exp=6", wcnt); end
    drv(); m1_wr = 1'b0; samp();
    n_cmp++; if ({s_write_o, m0_waitrequest_o} !== 2'b01) begin n_err++; $display("FAIL stall_m0_idle got=%b exp=01", {s_write_o, m0_waitrequest_o}); end
    drv(); samp();
    n_cmp++; if ({s_write_o, owner_o, m0_waitrequest_o} !== 3'b100 || s_address_o !== 14'd7) begin n_err++; $display("FAIL stall_m0_grant got=%b addr=%0d exp=100 addr=7", {s_write_o, owner_o, m0_waitrequest_o}, s_address_o); end
    drv(); m0_wr = 1'b0; samp();
  endtask

  task automatic test_timeout();
    drv(); m0_rd = 1'b1; m0_addr = 14'd9; exp_q.push_back('{m: 1'b0, d: 16'hDEAD}); samp();
    drv(); samp();
    n_cmp++; if ({s_read_o, owner_o} !== 2'b10) begin n_err++; $display("FAIL to_xfer got=%b exp=10", {s_read_o, owner_o}); end
    drv(); m0_rd = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i > 0) drv();
      samp();
      n_cmp++; if (err_timeout_o !== (i == 15)) begin n_err++; $display("FAIL to_pulse cyc=%0d got=%b exp=%b", i, err_timeout_o, (i == 15)); end
    end
    drv(); m1_wr = 1'b1; m1_addr = 14'd10; samp();
    n_cmp++; if ({err_timeout_o, m1_waitrequest_o} !== 2'b01) begin n_err++; $display("FAIL to_after got=%b exp=01", {err_timeout_o, m1_waitrequest_o}); end
    drv(); samp();
    n_cmp++; if ({s_write_o, owner_o, m1_waitrequest_o} !== 3'b110 || s_address_o !== 14'd10) begin n_err++; $display("FAIL to_next_grant got=%b addr=%0d exp=110 addr=10", {s_write_o, owner_o, m1_waitrequest_o}, s_address_o); end
    drv(); m1_wr = 1'b0; samp();
  endtask

  task automatic test_race();
    drv(); m1_rd = 1'b1; m1_addr = 14'd11; exp_q.push_back('{m: 1'b1, d: 16'hABCD}); samp();
    drv(); samp();
    drv(); m1_rd = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i > 0) drv();
      if (i == 15) begin s_rdv = 1'b1; s_rdata = 16'hABCD; end
      samp();
      n_cmp++; if ({err_timeout_o, err_stray_o} !== 2'b00) begin n_err++; $display("FAIL race_err cyc=%0d got=%b exp=00", i, {err_timeout_o, err_stray_o}); end
    end
    drv(); s_rdv = 1'b0; samp();
  endtask

  task automatic test_stray();
    drv(); s_rdv = 1'b1; s_rdata = 16'h5555; samp();
    n_cmp++; if (err_stray_o !== 1'b1) begin n_err++; $display("FAIL stray_pulse got=%b exp=1", err_stray_o); end
    drv(); s_rdv = 1'b0; samp();
    n_cmp++; if (err_stray_o !== 1'b0) begin n_err++; $display("FAIL stray_clear got=%b exp=0", err_stray_o); end
  endtask

  task automatic test_drop();
    drv(); m0_wr = 1'b1; m0_addr = 14'd12; s_wait = 1'b1; samp();
    drv(); samp();
    n_cmp++; if ({s_write_o, owner_o} !== 2'b10) begin n_err++; $display("FAIL drop_grant got=%b exp=10", {s_write_o, owner_o}); end
    drv(); m0_wr = 1'b0; samp();
    n_cmp++; if (s_write_o !== 1'b0) begin n_err++; $display("FAIL drop_strobe got=%b exp=0", s_write_o); end
    drv(); m1_wr = 1'b1; m1_addr = 14'd13; s_wait = 1'b0; samp();
    drv(); samp();
    n_cmp++; if ({s_write_o, owner_o} !== 2'b11 || s_address_o !== 14'd13) begin n_err++; $display("FAIL drop_recover got=%b addr=%0d exp=11 addr=13", {s_write_o, owner_o}, s_address_o); end
    drv(); m1_wr = 1'b0; samp();
  endtask

  task automatic test_reset_mid();
    drv(); m0_rd = 1'b1; m0_addr = 14'd14; samp();
    drv(); samp();
    drv(); m0_rd = 1'b0; samp();
    drv(); samp();
    n_cmp++; if (owner_o !== 1'b0) begin n_err++; $display("FAIL rmid_pre_owner got=%b exp=0", owner_o); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({owner_o, s_read_o, err_timeout_o, err_stray_o, m0_waitrequest_o} !== 5'b10000) begin n_err++; $display("FAIL rmid_async got=%b exp=10000", {owner_o, s_read_o, err_timeout_o, err_stray_o, m0_waitrequest_o}); end
    samp();
    rst_n = 1'b1;
    drv(); s_rdv = 1'b1; s_rdata = 16'h9999; samp();
    n_cmp++; if (err_stray_o !== 1'b1) begin n_err++; $display("FAIL rmid_late_stray got=%b exp=1", err_stray_o); end
    drv(); s_rdv = 1'b0; samp();
  endtask

  initial begin
    test_reset();
    test_rr_read();
    test_write();
    test_stall();
    test_timeout();
    test_race();
    test_stray();
    test_drop();
    test_reset_mid();
    drv(); samp();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
